// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-access stage.
package mem_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int RD_W_DEF   = 3;

    // Load data reported for stores and aborted accesses
    localparam logic [DATA_W_DEF-1:0] MEM_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register; a bubble kills the write-back enable and holds the rest.
module mem_wb_reg import mem_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              bubble,
    input  logic              memToRegNxt,
    input  logic              regWriteNxt,
    input  logic [DATA_W-1:0] aluResNxt,
    input  logic [DATA_W-1:0] memDataNxt,
    input  logic [RD_W-1:0]   rdNxt,
    output logic              memToRegWB,
    output logic              regWriteWB,
    output logic [DATA_W-1:0] aluResWB,
    output logic [DATA_W-1:0] memDataWB,
    output logic [RD_W-1:0]   rdWB
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memToRegWB <= 1'b0;
            regWriteWB <= 1'b0;
            aluResWB   <= '0;
            memDataWB  <= '0;
            rdWB       <= '0;
        end else if (bubble) begin
            regWriteWB <= 1'b0;
        end else if (en) begin
            memToRegWB <= memToRegNxt;
            regWriteWB <= regWriteNxt;
            aluResWB   <= aluResNxt;
            memDataWB  <= memDataNxt;
            rdWB       <= rdNxt;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack port, stalls upstream
// while an access is outstanding and registers results into MEM/WB.
module mem_stage import mem_pkg::*; #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memReadMEM,
    input  logic              memWriteMEM,
    input  logic              memToRegMEM,
    input  logic              regWriteMEM,
    input  logic [DATA_W-1:0] aluResMEM,
    input  logic [DATA_W-1:0] readData2MEM,
    input  logic [RD_W-1:0]   rdMEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              memStall,
    output logic              mem_err,
    output logic              memToRegWB,
    output logic              regWriteWB,
    output logic [DATA_W-1:0] aluResWB,
    output logic [DATA_W-1:0] memDataWB,
    output logic [RD_W-1:0]   rdWB
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [DATA_W-1:0] ZERO = DATA_W'(MEM_ZERO);

    state_t            state, stateNxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] loadData, memDataNxt;
    logic              access, isLoad, expired;
    logic              stallRaw, wbEn, wbBubble;

    assign access  = memReadMEM | memWriteMEM;
    assign isLoad  = memReadMEM & ~memWriteMEM;
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:    if (access) stateNxt = WAIT;
            WAIT:    if (dmem_ack || expired) stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        stallRaw   = 1'b0;
        wbEn       = 1'b0;
        wbBubble   = 1'b0;
        memDataNxt = ZERO;
        unique case (state)
            IDLE: begin
                stallRaw = access;
                wbBubble = access;
                wbEn     = ~access;
            end
            WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = memWriteMEM;
                dmem_addr  = aluResMEM[ADDR_W-1:0];
                dmem_wdata = readData2MEM;
                stallRaw   = 1'b1;
                wbBubble   = 1'b1;
            end
            DONE: begin
                wbEn       = 1'b1;
                memDataNxt = loadData;
            end
            default: ;
        endcase
    end

    // Upstream must not stay frozen while the stage is held in reset
    assign memStall = stallRaw & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            loadData <= '0;
            mem_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (access) cnt <= '0;
                WAIT: begin
                    if (dmem_ack) begin
                        loadData <= isLoad ? dmem_rdata : ZERO;
                    end else if (expired) begin
                        mem_err  <= 1'b1;
                        loadData <= ZERO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    mem_wb_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) u_memWb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (wbEn),
        .bubble     (wbBubble),
        .memToRegNxt(memToRegMEM),
        .regWriteNxt(regWriteMEM),
        .aluResNxt  (aluResMEM),
        .memDataNxt (memDataNxt),
        .rdNxt      (rdMEM),
        .memToRegWB (memToRegWB),
        .regWriteWB (regWriteWB),
        .aluResWB   (aluResWB),
        .memDataWB  (memDataWB),
        .rdWB       (rdWB)
    );
endmodule
